shift_rows: RTL and testbench



---
 rtl/shift_rows.sv | 60 ++++++
 tb/tb_shift_rows.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/shift_rows.sv
// AES ShiftRows / InvShiftRows pipeline stage: pure byte routing of the
// 128-bit state followed by one output register with a matching valid flag.
module shift_rows #(
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inv,
  input  logic [127:0] a,
  output logic         out_valid,
  output logic [127:0] b
);

  logic [127:0] fwd_s;
  logic [127:0] inv_s;
  logic [127:0] perm_s;
  logic [127:0] b_d;
  logic [127:0] b_q;
  logic         out_valid_q;

  // Element (row r, col c) lives in byte 4c+r; rows rotate left (fwd) or right (inv) by r.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign fwd_s[8*(4*c+r) +: 8] = a[8*(4*((c+r)%4)+r) +: 8];
      assign inv_s[8*(4*c+r) +: 8] = a[8*(4*((c-r+4)%4)+r) +: 8];
    end
  end

  // Mode select and load/hold next-state for the output register.
  always_comb begin
    perm_s = fwd_s;
    b_d    = b_q;
    if ((INV_EN == 1'b1) && inv) begin
      perm_s = inv_s;
    end else begin
      perm_s = fwd_s;
    end
    if (in_valid) begin
      b_d = perm_s;
    end else begin
      b_d = b_q;
    end
  end

  // Output pipeline register; valid tracks in_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q         <= 128'h0;
      out_valid_q <= 1'b0;
    end else begin
      b_q         <= b_d;
      out_valid_q <= in_valid;
    end
  end

  assign b         = b_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_rows.sv
// Self-checking bench for shift_rows: directed vectors, reset behaviour and a
// randomized round-trip stream checked against a queue-based row-rotation model.
module tb_shift_rows;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         inv;
  logic [127:0] a;
  logic         out_valid;
  logic [127:0] b;
  logic         out_valid_f;
  logic [127:0] b_f;

  int n_checks;
  int n_fail;

  shift_rows #(.INV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inv(inv),
    .a(a), .out_valid(out_valid), .b(b)
  );

  shift_rows #(.INV_EN(1'b0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inv(inv),
    .a(a), .out_valid(out_valid_f), .b(b_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: gather each row into a queue and rotate it r times.
  function automatic logic [127:0] ref_shift(input logic [127:0] s, input logic inv_m);
    logic [7:0] q[$];
    logic [127:0] o;
    o = 128'h0;
    for (int r = 0; r < 4; r++) begin
      q.delete();
      for (int c = 0; c < 4; c++) q.push_back(s[8*(4*c+r) +: 8]);
      for (int k = 0; k < r; k++) begin
        if (!inv_m) q.push_back(q.pop_front());
        else        q.push_front(q.pop_back());
      end
      for (int c = 0; c < 4; c++) o[8*(4*c+r) +: 8] = q[c];
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] pat;
  logic [127:0] last_b;
  logic [127:0] x;
  logic [127:0] y;
  logic [127:0] aa;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    inv      = 1'b0;
    a        = 128'h0;
    pat      = 128'h0F0E0D0C0B0A09080706050403020100;

    #1;
    check_eq("reset_b", b, 128'h0);
    check_eq("reset_valid", {127'h0, out_valid}, 128'h0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_release_valid", {127'h0, out_valid}, 128'h0);

    // Directed forward
    a = pat; inv = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("fwd_b", b, 128'h0B06010C07020D08030E09040F0A0500);
    check_eq("fwd_model", b, ref_shift(pat, 1'b0));
    check_eq("fwd_valid", {127'h0, out_valid}, 128'h1);

    // Directed inverse; forward-only build must ignore inv
    a = pat; inv = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("inv_b", b, 128'h0306090C0F0205080B0E0104070A0D00);
    check_eq("inv_model", b, ref_shift(pat, 1'b1));
    check_eq("inv_valid", {127'h0, out_valid}, 128'h1);
    check_eq("fwd_only_ignores_inv", b_f, 128'h0B06010C07020D08030E09040F0A0500);

    // Hold for 3 idle cycles
    last_b = 128'h0306090C0F0205080B0E0104070A0D00;
    a = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("hold_valid_%0d", i), {127'h0, out_valid}, 128'h0);
      check_eq($sformatf("hold_b_%0d", i), b, last_b);
    end

    // Invariance: uniform state unchanged in both modes
    aa = {16{8'hA5}};
    for (int m = 0; m < 2; m++) begin
      a = aa; inv = m[0]; in_valid = 1'b1;
      step();
      check_eq($sformatf("invariant_%0d", m), b, aa);
    end

    // Round trip streaming: inv alternates each cycle, no bubbles
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = ref_shift(x, 1'b0);
      a = x; inv = 1'b0; in_valid = 1'b1;
      step();
      check_eq("stream_fwd", b, y);
      check_eq("stream_fwd_valid", {127'h0, out_valid}, 128'h1);
      check_eq("stream_fwd_only", b_f, y);
      a = y; inv = 1'b1;
      step();
      check_eq("roundtrip", b, x);
      check_eq("stream_inv_valid", {127'h0, out_valid}, 128'h1);
    end

    // Reset mid-stream: asynchronous clear, in-flight state discarded
    a = pat; inv = 1'b0; in_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_b_async", b, 128'h0);
    check_eq("midrst_valid_async", {127'h0, out_valid}, 128'h0);
    step();
    check_eq("midrst_b_held", b, 128'h0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    check_eq("post_rst_idle_valid", {127'h0, out_valid}, 128'h0);
    check_eq("post_rst_idle_b", b, 128'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("post_rst_first_b", b, 128'h0B06010C07020D08030E09040F0A0500);
    check_eq("post_rst_first_valid", {127'h0, out_valid}, 128'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
